halfband_interp: RTL and testbench

- 2x interpolating 11-tap halfband FIR: the upsampling counterpart of the decimating halfband chain, feeding playback/test-tone paths at twice the input rate.
- Same fixed Q1.20 symmetric coefficients as the decimator; polyphase form with one time-shared multiplier.
- Per accepted input x[n], emits an even-phase filtered sample, then an odd-phase sample, over ready/valid handshakes.

---
 rtl/halfband_interp_if.sv | 24 ++
 rtl/halfband_interp.sv | 148 ++++++++++++++
 tb/tb_halfband_interp.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halfband_interp_if.sv
// Handshake bundle for the 2x halfband interpolator: input sample stream in,
// interleaved even/odd output stream out.
interface halfband_interp_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_phase;
    logic                 sat_flag;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_phase, sat_flag
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_phase, sat_flag
    );
endinterface

// File: rtl/halfband_interp.sv
// 2x interpolating 11-tap halfband FIR, polyphase form with one shared multiplier.
// Each input yields an even (filtered) sample followed by an odd (centre-tap) sample.
module halfband_interp #(
    parameter int                 DW   = 16,
    parameter int                 ACCW = 48,
    parameter logic signed [24:0] C0   = 25'sh0002090,
    parameter logic signed [24:0] C2   = 25'sh1FF2158,
    parameter logic signed [24:0] C4   = 25'sh004BE38
) (
    input  logic             clkdiv,
    input  logic             rst,
    halfband_interp_if.slave bus
);
    localparam int MW = 25 + DW + 1;
    // Shift by 19 instead of 20 folds in the x2 interpolation gain.
    localparam int SH = 19;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MAC0 = 3'd1;
    localparam logic [2:0] MAC1 = 3'd2;
    localparam logic [2:0] MAC2 = 3'd3;
    localparam logic [2:0] OUT0 = 3'd4;
    localparam logic [2:0] OUT1 = 3'd5;

    localparam logic signed [ACCW-1:0] HALF = ACCW'(longint'(1) <<< (SH - 1));
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((longint'(1) <<< (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    logic [2:0]            state_q, state_d;
    logic [5:0][DW-1:0]    dly_q, dly_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [DW-1:0]  out_data_q, out_data_d;
    logic                  sat_flag_q, sat_flag_d;

    logic                  accept;
    logic signed [24:0]    coef;
    logic signed [DW-1:0]  tap_a, tap_b;
    logic signed [DW:0]    pre_sum;
    logic signed [MW-1:0]  prod;
    logic signed [ACCW-1:0] acc_in, sum, biased, rnd;
    logic signed [DW-1:0]  sat_val;
    logic                  sat_hit;

    assign accept = bus.in_valid && (state_q == IDLE);

    // Symmetric taps share one coefficient, so each MAC state pre-adds a mirrored pair.
    always_comb begin
        coef  = C0;
        tap_a = dly_q[0];
        tap_b = dly_q[5];
        case (state_q)
            MAC1: begin
                coef  = C2;
                tap_a = dly_q[1];
                tap_b = dly_q[4];
            end
            MAC2: begin
                coef  = C4;
                tap_a = dly_q[2];
                tap_b = dly_q[3];
            end
            default: ;
        endcase
    end

    assign pre_sum = (DW + 1)'(tap_a) + (DW + 1)'(tap_b);
    assign prod    = MW'(coef) * MW'(pre_sum);
    assign acc_in  = (state_q == MAC0) ? '0 : acc_q;
    assign sum     = acc_in + ACCW'(prod);
    assign biased  = sum + HALF;
    assign rnd     = biased >>> SH;

    always_comb begin
        sat_hit = 1'b0;
        sat_val = DW'(rnd);
        if (rnd > MAXV) begin
            sat_hit = 1'b1;
            sat_val = {1'b0, {(DW - 1){1'b1}}};
        end else if (rnd < MINV) begin
            sat_hit = 1'b1;
            sat_val = {1'b1, {(DW - 1){1'b0}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        sat_flag_d = sat_flag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dly_d   = {dly_q[4:0], bus.in_data};
                    state_d = MAC0;
                end
            end
            MAC0: begin
                acc_d   = sum;
                state_d = MAC1;
            end
            MAC1: begin
                acc_d   = sum;
                state_d = MAC2;
            end
            MAC2: begin
                acc_d      = sum;
                out_data_d = sat_val;
                sat_flag_d = sat_hit;
                state_d    = OUT0;
            end
            OUT0: begin
                // Odd phase is the centre tap: 0.5 * gain 2 passes x[n-2] through exactly.
                if (bus.out_ready) begin
                    out_data_d = dly_q[2];
                    sat_flag_d = 1'b0;
                    state_d    = OUT1;
                end
            end
            OUT1: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT0) || (state_q == OUT1);
    assign bus.out_phase = (state_q == OUT1);
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_halfband_interp.sv
// Bench for halfband_interp: directed impulse/DC/backpressure/throughput/reset
// scenarios plus randomized traffic against a direct-convolution reference.
module tb_halfband_interp;
    logic clkdiv;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    longint hx[6];

    halfband_interp_if #(.DW(16)) bus ();

    halfband_interp #(.DW(16)) dut (
        .clkdiv (clkdiv),
        .rst    (rst),
        .bus    (bus)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    // Impulse response (even polyphase branch) in Q1.20.
    function automatic longint tap(input int k);
        case (k)
            0, 5:    return 64'sd8336;
            1, 4:    return -64'sd57000;
            default: return 64'sd310840;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) hx[i] = 0;
    endfunction

    // y_even = sat(floor((sum h*x)*2 / 2^20 + 0.5)), y_odd = x[n-2]
    function automatic void model_push(input int x, output int ev, output bit es, output int od);
        longint s, r;
        for (int k = 5; k > 0; k--) hx[k] = hx[k-1];
        hx[0] = x;
        s = 0;
        for (int k = 0; k < 6; k++) s += tap(k) * hx[k];
        r = (s + 64'sd262144) >>> 19;
        es = 1'b0;
        if (r > 32767) begin r = 32767; es = 1'b1; end
        else if (r < -32768) begin r = -32768; es = 1'b1; end
        ev = int'(r);
        od = int'(hx[2]);
    endfunction

    // Push one sample and collect its two outputs; starts and ends on a negedge.
    task automatic xfer(input int x, input int rdy_pct,
                        output int ev, output bit es, output int od, output bit os,
                        output bit p0, output bit p1, output bit ok);
        int t, got;
        ok = 1'b1; ev = 0; es = 1'b0; od = 0; os = 1'b0; p0 = 1'b1; p1 = 1'b0;
        bus.in_data  = 16'(x);
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin @(negedge clkdiv); t++; end
        if (t >= 20) begin bus.in_valid = 1'b0; ok = 1'b0; return; end
        @(negedge clkdiv);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        got = 0;
        t = 0;
        while (got < 2 && t < 200) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                if (got == 0) begin
                    ev = int'(bus.out_data); es = bus.sat_flag; p0 = bus.out_phase;
                end else begin
                    od = int'(bus.out_data); os = bus.sat_flag; p1 = bus.out_phase;
                end
                got++;
            end
            @(negedge clkdiv);
            t++;
        end
        bus.out_ready = 1'b0;
        if (got < 2) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clkdiv);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.sat_flag !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.out_phase !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%0d sat=%b ready=%b phase=%b want 0/0/0/1/0",
                     bus.out_valid, bus.out_data, bus.sat_flag, bus.in_ready, bus.out_phase);
        end
        bus.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clkdiv);
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_idle: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_impulse(input string tag);
        int ev_tab[10];
        int od_tab[10];
        int ev, od;
        bit es, os, p0, p1, ok;
        ev_tab = '{261, -1781, 9714, 9714, -1781, 261, 0, 0, 0, 0};
        od_tab = '{0, 0, 16384, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 10; n++) begin
            int x, mev, mod_;
            bit mes;
            x = (n == 0) ? 16384 : 0;
            model_push(x, mev, mes, mod_);
            xfer(x, 100, ev, es, od, os, p0, p1, ok);
            n_cmp++;
            if (!ok || ev !== ev_tab[n] || od !== od_tab[n] || es !== 1'b0 || os !== 1'b0) begin
                n_err++;
                $display("FAIL %s n%0d: got (%0d,%0d) sat=%b/%b ok=%b want (%0d,%0d) sat=0/0",
                         tag, n, ev, od, es, os, ok, ev_tab[n], od_tab[n]);
            end
            n_cmp++;
            if (p0 !== 1'b0 || p1 !== 1'b1) begin
                n_err++;
                $display("FAIL %s_phase n%0d: got %b,%b want 0,1", tag, n, p0, p1);
            end
        end
    endtask

    task automatic test_dc(input int val);
        int ev, od, mev, mod_;
        bit es, os, p0, p1, ok, mes;
        for (int n = 0; n < 9; n++) begin
            model_push(val, mev, mes, mod_);
            xfer(val, 80, ev, es, od, os, p0, p1, ok);
            n_cmp++;
            if (!ok || ev !== mev || es !== mes || od !== mod_ || os !== 1'b0) begin
                n_err++;
                $display("FAIL dc_model %0d n%0d: got (%0d,%0d) sat=%b ok=%b want (%0d,%0d) sat=%b",
                         val, n, ev, od, es, ok, mev, mod_, mes);
            end
            if (n >= 5) begin
                n_cmp++;
                if (ev !== val || es !== 1'b1 || od !== val) begin
                    n_err++;
                    $display("FAIL dc_steady %0d n%0d: got (%0d,%0d) sat=%b want (%0d,%0d) sat=1",
                             val, n, ev, od, es, val, val);
                end
            end
        end
    endtask

    task automatic test_random();
        int ev, od, mev, mod_, x;
        bit es, os, p0, p1, ok, mes;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(4))
                0:       x = 32767;
                1:       x = -32768;
                default: x = int'($urandom_range(65535)) - 32768;
            endcase
            repeat ($urandom_range(2)) @(negedge clkdiv);
            model_push(x, mev, mes, mod_);
            xfer(x, 60, ev, es, od, os, p0, p1, ok);
            n_cmp++;
            if (!ok || ev !== mev || es !== mes || od !== mod_ || os !== 1'b0 ||
                p0 !== 1'b0 || p1 !== 1'b1) begin
                n_err++;
                $display("FAIL random n%0d x=%0d: got (%0d,%0d) sat=%b ph=%b%b ok=%b want (%0d,%0d) sat=%b",
                         n, x, ev, od, es, p0, p1, ok, mev, mod_, mes);
            end
        end
    endtask

    task automatic test_backpressure();
        int x, mev, mod_, t, ev, od;
        bit mes, es, os, p0, p1, ok;
        logic signed [15:0] d0;
        logic s0;
        x = 20000;
        model_push(x, mev, mes, mod_);
        bus.in_data = 16'(x); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin @(negedge clkdiv); t++; end
        @(negedge clkdiv);
        bus.in_data = 16'sd12345;
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 10) begin @(negedge clkdiv); t++; end
        d0 = bus.out_data;
        s0 = bus.sat_flag;
        n_cmp++;
        if (t >= 10 || int'(d0) !== mev || s0 !== mes || bus.out_phase !== 1'b0) begin
            n_err++;
            $display("FAIL bp_even: got %0d sat=%b phase=%b wait=%0d want %0d sat=%b phase=0",
                     d0, s0, bus.out_phase, t, mev, mes);
        end
        repeat (10) begin
            @(negedge clkdiv);
            n_cmp++;
            if (bus.out_data !== d0 || bus.sat_flag !== s0 || bus.out_phase !== 1'b0 ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: data=%0d sat=%b ph=%b vld=%b rdy=%b want %0d/%b/0/1/0",
                         bus.out_data, bus.sat_flag, bus.out_phase, bus.out_valid, bus.in_ready, d0, s0);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clkdiv);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_phase !== 1'b1 || int'(bus.out_data) !== mod_ ||
            bus.sat_flag !== 1'b0) begin
            n_err++;
            $display("FAIL bp_odd: vld=%b ph=%b data=%0d sat=%b want 1/1/%0d/0",
                     bus.out_valid, bus.out_phase, bus.out_data, bus.sat_flag, mod_);
        end
        @(negedge clkdiv);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_idle: vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        // Follow-up samples expose any extra input swallowed while stalled.
        for (int n = 0; n < 3; n++) begin
            x = int'($urandom_range(65535)) - 32768;
            model_push(x, mev, mes, mod_);
            xfer(x, 100, ev, es, od, os, p0, p1, ok);
            n_cmp++;
            if (!ok || ev !== mev || es !== mes || od !== mod_) begin
                n_err++;
                $display("FAIL bp_after n%0d: got (%0d,%0d) sat=%b want (%0d,%0d) sat=%b",
                         n, ev, od, es, mev, mod_, mes);
            end
        end
    endtask

    task automatic test_throughput();
        int cnt, last, bad_gap;
        cnt = 0; last = -1; bad_gap = 0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            bus.in_data = 16'($urandom);
            if (bus.in_ready === 1'b1) begin
                if (last >= 0 && c - last != 6) bad_gap++;
                last = c;
                cnt++;
            end
            @(negedge clkdiv);
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (cnt !== 6 || bad_gap !== 0) begin
            n_err++;
            $display("FAIL throughput: in_ready high %0d of 36 cycles, %0d bad gaps; want 6, 0", cnt, bad_gap);
        end
        repeat (8) @(negedge clkdiv);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int t;
        bus.in_data = 16'sd30000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin @(negedge clkdiv); t++; end
        @(negedge clkdiv);
        bus.in_valid = 1'b0;
        @(negedge clkdiv);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.sat_flag !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.out_phase !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset: vld=%b data=%0d sat=%b rdy=%b ph=%b want 0/0/0/1/0",
                     bus.out_valid, bus.out_data, bus.sat_flag, bus.in_ready, bus.out_phase);
        end
        @(negedge clkdiv);
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clkdiv);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midop_no_output: out_valid=%b want 0", bus.out_valid);
            end
        end
        bus.out_ready = 1'b0;
        test_impulse("impulse_after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clkdiv);
        test_reset();
        test_impulse("impulse");
        test_dc(32767);
        test_dc(-32768);
        test_random();
        test_backpressure();
        test_throughput();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
